// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store responder.
// Single-outstanding valid/ready bus master with pipeline hold.
module mem_access_unit #(
  parameter int XLEN   = 64,
  parameter int STRB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              visit_sig_i,
  input  logic              wmem_en_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  output logic              hold,
  output logic [XLEN-1:0]   rdata_o,
  output logic              done_o,
  output logic              misalign_o,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [STRB_W-1:0] bus_wstrb,
  input  logic              bus_rvalid,
  input  logic [XLEN-1:0]   bus_rdata
);

  localparam int OFF_W = $clog2(STRB_W);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] WAIT_R = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]        state;
  logic              misalign;
  logic              start;
  logic [OFF_W-1:0]  off;
  logic [STRB_W-1:0] base;
  logic [XLEN-1:0]   lane_wdata;
  logic [STRB_W-1:0] lane_wstrb;
  logic [XLEN-1:0]   lane_addr;

  logic [OFF_W-1:0]  r_off;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [XLEN-1:0]   sh;
  logic [XLEN-1:0]   load_val;

  assign off = addr_i[OFF_W-1:0];

  // Natural-alignment check on the incoming request.
  always_comb begin
    misalign = 1'b0;
    unique case (size_i)
      2'd0: misalign = 1'b0;
      2'd1: misalign = addr_i[0];
      2'd2: misalign = |addr_i[1:0];
      2'd3: misalign = |addr_i[2:0];
      default: misalign = 1'b0;
    endcase
  end

  assign start = (state == IDLE) && visit_sig_i && !misalign;

  // Stall and misalign flags, both suppressed during reset.
  always_comb begin
    hold       = 1'b0;
    misalign_o = 1'b0;
    if (!rst) begin
      hold = (state == REQ) || (state == WAIT_R) || start;
      misalign_o = (state == IDLE) && visit_sig_i && misalign;
    end
  end

  // Byte-lane placement of store data and strobes.
  always_comb begin
    base = '0;
    unique case (size_i)
      2'd0: base = STRB_W'(8'h01);
      2'd1: base = STRB_W'(8'h03);
      2'd2: base = STRB_W'(8'h0F);
      2'd3: base = STRB_W'(8'hFF);
      default: base = '0;
    endcase
    lane_wstrb = base << off;
    lane_wdata = wdata_i << {off, 3'b000};
    lane_addr  = {addr_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
  end

  // Extract and extend the addressed field of the read beat.
  always_comb begin
    sh       = bus_rdata >> {r_off, 3'b000};
    load_val = sh;
    unique case (r_size)
      2'd0: load_val = r_uns ?
        {{(XLEN-8){1'b0}}, sh[7:0]} :
        {{(XLEN-8){sh[7]}}, sh[7:0]};
      2'd1: load_val = r_uns ?
        {{(XLEN-16){1'b0}}, sh[15:0]} :
        {{(XLEN-16){sh[15]}}, sh[15:0]};
      2'd2: load_val = r_uns ?
        {{(XLEN-32){1'b0}}, sh[31:0]} :
        {{(XLEN-32){sh[31]}}, sh[31:0]};
      2'd3: load_val = sh;
      default: load_val = sh;
    endcase
  end

  // Access FSM with registered bus and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
      rdata_o   <= '0;
      done_o    <= 1'b0;
      r_off     <= '0;
      r_size    <= 2'd0;
      r_uns     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= REQ;
            bus_valid <= 1'b1;
            bus_we    <= wmem_en_i;
            bus_addr  <= lane_addr;
            bus_wdata <= lane_wdata;
            bus_wstrb <= lane_wstrb;
            r_off     <= off;
            r_size    <= size_i;
            r_uns     <= unsigned_i;
          end
        end
        REQ: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            if (bus_we) begin
              state   <= DONE;
              done_o  <= 1'b1;
              rdata_o <= '0;
            end else begin
              state <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (bus_rvalid) begin
            state   <= DONE;
            done_o  <= 1'b1;
            rdata_o <= load_val;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench for mem_access_unit.
// Drives and samples on the falling edge.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        visit_sig_i;
  logic        wmem_en_i;
  logic [63:0] addr_i;
  logic [63:0] wdata_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic        hold;
  logic [63:0] rdata_o;
  logic        done_o;
  logic        misalign_o;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_rvalid;
  logic [63:0] bus_rdata;

  int vectors = 0;
  int errs    = 0;

  mem_access_unit dut (
    .clk         (clk),
    .rst         (rst),
    .visit_sig_i (visit_sig_i),
    .wmem_en_i   (wmem_en_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .size_i      (size_i),
    .unsigned_i  (unsigned_i),
    .hold        (hold),
    .rdata_o     (rdata_o),
    .done_o      (done_o),
    .misalign_o  (misalign_o),
    .bus_valid   (bus_valid),
    .bus_ready   (bus_ready),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_wstrb   (bus_wstrb),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic drive(input logic v,
                       input logic we,
                       input logic [63:0] a,
                       input logic [63:0] wd,
                       input logic [1:0] sz,
                       input logic u);
    visit_sig_i = v;
    wmem_en_i   = we;
    addr_i      = a;
    wdata_i     = wd;
    size_i      = sz;
    unsigned_i  = u;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, {63'd0, bus_valid}, 64'd0);
    chk({tag, ".we"},    {63'd0, bus_we}, 64'd0);
    chk({tag, ".addr"},  bus_addr, 64'd0);
    chk({tag, ".wdata"}, bus_wdata, 64'd0);
    chk({tag, ".wstrb"}, {56'd0, bus_wstrb}, 64'd0);
    chk({tag, ".rdata"}, rdata_o, 64'd0);
    chk({tag, ".done"},  {63'd0, done_o}, 64'd0);
    chk({tag, ".hold"},  {63'd0, hold}, 64'd0);
    chk({tag, ".mis"},   {63'd0, misalign_o}, 64'd0);
  endtask

  task automatic do_load(input string tag,
                         input logic [63:0] a,
                         input logic [1:0] sz,
                         input logic u,
                         input logic [63:0] rd,
                         input logic [63:0] exp);
    logic [63:0] al;
    al = a & ~64'h7;
    @(negedge clk);
    drive(1'b1, 1'b0, a, 64'd0, sz, u);
    bus_ready = 1'b1;
    #1 chk({tag, ".hold0"}, {63'd0, hold}, 64'd1);
    @(negedge clk);
    chk({tag, ".valid"}, {63'd0, bus_valid}, 64'd1);
    chk({tag, ".addr"}, bus_addr, al);
    chk({tag, ".we"}, {63'd0, bus_we}, 64'd0);
    bus_rvalid = 1'b1;
    bus_rdata  = ~rd;
    @(negedge clk);
    chk({tag, ".done_w"}, {63'd0, done_o}, 64'd0);
    chk({tag, ".hold_w"}, {63'd0, hold}, 64'd1);
    chk({tag, ".valid_w"}, {63'd0, bus_valid}, 64'd0);
    bus_rdata = rd;
    @(negedge clk);
    bus_rvalid = 1'b0;
    chk({tag, ".done"}, {63'd0, done_o}, 64'd1);
    chk({tag, ".rdata"}, rdata_o, exp);
    chk({tag, ".hold_d"}, {63'd0, hold}, 64'd0);
    drive(1'b0, 1'b0, 64'd0, 64'd0, 2'd0, 1'b0);
    @(negedge clk);
    chk({tag, ".done_end"}, {63'd0, done_o}, 64'd0);
    chk({tag, ".rd_hold"}, rdata_o, exp);
  endtask

  initial begin
    rst = 1'b1;
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = 64'd0;
    drive(1'b0, 1'b0, 64'd0, 64'd0, 2'd0, 1'b0);
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // store byte
    @(negedge clk);
    drive(1'b1, 1'b1, 64'h1003, 64'hAB, 2'd0, 1'b0);
    bus_ready = 1'b1;
    #1 chk("sb.hold0", {63'd0, hold}, 64'd1);
    chk("sb.valid0", {63'd0, bus_valid}, 64'd0);
    @(negedge clk);
    chk("sb.valid", {63'd0, bus_valid}, 64'd1);
    chk("sb.addr", bus_addr, 64'h1000);
    chk("sb.wstrb", {56'd0, bus_wstrb}, 64'h08);
    chk("sb.wdata", bus_wdata, 64'h00000000AB000000);
    chk("sb.we", {63'd0, bus_we}, 64'd1);
    chk("sb.hold1", {63'd0, hold}, 64'd1);
    chk("sb.done1", {63'd0, done_o}, 64'd0);
    @(negedge clk);
    chk("sb.done", {63'd0, done_o}, 64'd1);
    chk("sb.hold2", {63'd0, hold}, 64'd0);
    chk("sb.valid2", {63'd0, bus_valid}, 64'd0);
    chk("sb.rdata", rdata_o, 64'd0);
    drive(1'b0, 1'b0, 64'd0, 64'd0, 2'd0, 1'b0);
    @(negedge clk);
    chk("sb.done3", {63'd0, done_o}, 64'd0);

    do_load("lh", 64'h2006, 2'd1, 1'b0,
            64'h8123_0000_0000_0000,
            64'hFFFF_FFFF_FFFF_8123);
    do_load("lhu", 64'h2006, 2'd1, 1'b1,
            64'h8123_0000_0000_0000,
            64'h0000_0000_0000_8123);
    do_load("lw", 64'h2004, 2'd2, 1'b0,
            64'h8000_0001_0000_0000,
            64'hFFFF_FFFF_8000_0001);
    do_load("lb", 64'h2001, 2'd0, 1'b0,
            64'h0000_0000_0000_F000,
            64'hFFFF_FFFF_FFFF_FFF0);

    // back-to-back: stale request held through DONE
    @(negedge clk);
    drive(1'b1, 1'b1, 64'h6000, 64'h11223344, 2'd2, 1'b0);
    bus_ready = 1'b1;
    @(negedge clk);
    chk("bb.wstrb", {56'd0, bus_wstrb}, 64'h0F);
    chk("bb.wdata", bus_wdata, 64'h11223344);
    @(negedge clk);
    chk("bb.done", {63'd0, done_o}, 64'd1);
    chk("bb.rdata", rdata_o, 64'd0);
    @(negedge clk);
    chk("bb.nostale", {63'd0, bus_valid}, 64'd0);
    drive(1'b1, 1'b0, 64'h6008, 64'd0, 2'd3, 1'b0);
    #1 chk("bb.hold_new", {63'd0, hold}, 64'd1);
    @(negedge clk);
    chk("bb.valid_new", {63'd0, bus_valid}, 64'd1);
    chk("bb.addr_new", bus_addr, 64'h6008);
    chk("bb.we_new", {63'd0, bus_we}, 64'd0);
    @(negedge clk);
    bus_rvalid = 1'b1;
    bus_rdata  = 64'hCAFEBABE_12345678;
    @(negedge clk);
    bus_rvalid = 1'b0;
    chk("bb.done_new", {63'd0, done_o}, 64'd1);
    chk("bb.rd_new", rdata_o, 64'hCAFEBABE_12345678);
    drive(1'b0, 1'b0, 64'd0, 64'd0, 2'd0, 1'b0);

    // ready backpressure on dword store
    @(negedge clk);
    drive(1'b1, 1'b1, 64'h3000,
          64'h0123_4567_89AB_CDEF, 2'd3, 1'b0);
    bus_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.valid", {63'd0, bus_valid}, 64'd1);
      chk("bp.addr", bus_addr, 64'h3000);
      chk("bp.wdata", bus_wdata, 64'h0123_4567_89AB_CDEF);
      chk("bp.wstrb", {56'd0, bus_wstrb}, 64'hFF);
      chk("bp.hold", {63'd0, hold}, 64'd1);
      chk("bp.done", {63'd0, done_o}, 64'd0);
    end
    @(negedge clk);
    bus_ready = 1'b1;
    chk("bp.valid6", {63'd0, bus_valid}, 64'd1);
    @(negedge clk);
    chk("bp.done_hs", {63'd0, done_o}, 64'd1);
    chk("bp.valid_hs", {63'd0, bus_valid}, 64'd0);
    drive(1'b0, 1'b0, 64'd0, 64'd0, 2'd0, 1'b0);

    // misaligned word load
    @(negedge clk);
    drive(1'b1, 1'b0, 64'h4002, 64'd0, 2'd2, 1'b0);
    #1 chk("mis.flag", {63'd0, misalign_o}, 64'd1);
    chk("mis.hold", {63'd0, hold}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mis.valid", {63'd0, bus_valid}, 64'd0);
      chk("mis.flagN", {63'd0, misalign_o}, 64'd1);
      chk("mis.done", {63'd0, done_o}, 64'd0);
    end
    drive(1'b0, 1'b0, 64'd0, 64'd0, 2'd0, 1'b0);
    #1 chk("mis.clear", {63'd0, misalign_o}, 64'd0);

    // reset while waiting for read data
    @(negedge clk);
    drive(1'b1, 1'b0, 64'h5000, 64'd0, 2'd3, 1'b0);
    bus_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rw.inwait", {63'd0, hold}, 64'd1);
    rst = 1'b1;
    #1 chk_zero("rw.rst");
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 64'd0, 64'd0, 2'd0, 1'b0);
    bus_rvalid = 1'b1;
    bus_rdata  = 64'hDEAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rw.done", {63'd0, done_o}, 64'd0);
      chk("rw.rdata", rdata_o, 64'd0);
      chk("rw.valid", {63'd0, bus_valid}, 64'd0);
    end
    bus_rvalid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
